phase_to_amplitude: RTL
=======================

# phase_to_amplitude

Converts the running phase word from the tracker's phase accumulator into a signed audio sample. The waveform is square/pulse, sawtooth, triangle or noise. It sits directly downstream of the accumulator in each voice channel and feeds the channel mixer. The block is a 2-stage pipeline with a valid qualifier. It also flags phase wrap-around and advances a noise LFSR in step with the phase.

## Interface
- PHASE_WIDTH, 32: width of the incoming phase word. Must be ≥ SAMPLE_WIDTH+1.
- SAMPLE_WIDTH, 16: width of the output sample. Must be ≤ 23.
- clk  in  1  sole clock, rising edge.
- rst_active_high  in  1  asynchronous, active-high reset.
- phase_in  in  PHASE_WIDTH  unsigned phase from the accumulator.
- phase_valid  in  1  qualifies phase_in, wave_select and pulse_width this cycle.
- wave_select  in  3  waveform code:
  - 0: pulse
  - 1: saw
  - 2: triangle
  - 3: noise
  - 4-7: silence
- pulse_width  in  8  duty threshold for pulse.
- sample_out  out  SAMPLE_WIDTH  signed two's-complement sample.
- sample_valid  out  1  sample_out is new this cycle.
- wrap_pulse  out  1  the phase of this sample wrapped; coincident with sample_valid.

## Operation
- **Stage 1** registers the following when phase_valid=1:
  - phase_in, wave_select, pulse_width, plus a valid bit.
  - A wrap flag, set when phase_in < prev_phase (unsigned compare).
  - The LFSR step.
- **prev_phase** updates to phase_in only on valid cycles. Reset value is 0, so the first valid sample after reset never reports a wrap.
- **Noise LFSR**
  - 23-bit Fibonacci register, reset seed 0x7FFFFF.
  - Step: shift left, new bit0 = lfsr[22] ^ lfsr[17].
  - Steps once on a valid cycle when phase_in[P-1:P-4] != prev_phase[P-1:P-4], i.e. at most once per valid input.
  - Noise samples use the post-step value.
- **Stage 2** computes the waveform from the stage-1 registers and registers sample_out, sample_valid and wrap_pulse. Let S = SAMPLE_WIDTH and P = PHASE_WIDTH.
  - Saw: u = phase[P-1 -: S]; sample = u with its MSB inverted. Phase 0 → -2^(S-1); phase all-ones → 2^(S-1)-1.
  - Pulse: sample = 2^(S-1)-1 if phase[P-1 -: 8] < pulse_width, else -2^(S-1).
    - pulse_width 0 → constant low.
    - pulse_width 128 → 50 % duty.
  - Triangle: f = phase[P-2 -: S]; if phase[P-1]=1 then f = ~f; sample = f with its MSB inverted. This gives a rising ramp over the first half-cycle and a falling ramp over the second.
  - Noise: sample = lfsr[S-1:0], interpreted as signed.
  - Silence (codes 4-7): sample = 0.
- **Idle cycles** (phase_valid=0) insert a bubble:
  - No state updates: prev_phase and the LFSR hold.
  - sample_out holds its last value; sample_valid=0; wrap_pulse=0.
- wave_select and pulse_width are sampled per valid cycle. A change takes effect on the next valid sample with no glitch sample.

## Timing
- Latency is exactly 2 cycles: phase_valid high at edge N gives sample_valid high after edge N+2.
- Throughput is one sample per cycle. Back-to-back valids produce back-to-back outputs; there is no backpressure.
- wrap_pulse is a single-cycle pulse aligned with the sample_valid of the wrapping sample. It is never asserted while sample_valid=0.
- **Reset** (asynchronous assert; deassert is synchronised by the system) sets:
  - sample_out=0, sample_valid=0, wrap_pulse=0.
  - prev_phase=0, LFSR=0x7FFFFF, all pipeline valid bits 0.
- Reset mid-operation discards in-flight samples. No sample_valid appears for inputs accepted before reset.
- Wrap and LFSR step may occur in the same cycle; both take effect.
- There is no arithmetic overflow path: all waveforms are bit selects or inversions.

## Test plan
- Reset then saw (P=32, S=16):
  - Valid phases 0x00000000, 0x80000000, 0xFFFFFFFF → samples -32768, 0, 32767, arriving 2 cycles after each input.
  - wrap_pulse=0 throughout.
- Pulse, pulse_width=128: phases 0x7F000000 and 0x80000000 → 32767 then -32768. With pulse_width=0, every phase → -32768.
- Triangle: phases 0x00000000, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF → -32768, 32767, 32767, -32768.
- Wrap and noise:
  - Noise selected; phases 0x00000000 then 0x10000000 → one LFSR step, sample 0xFFFE (-2), wrap_pulse=0.
  - Next phase 0x00000001 → wrap_pulse=1 with that sample and another LFSR step.
- Bubbles: valid on cycles 0, 2, 3 only → sample_valid on cycles 2, 4, 5. sample_out holds during the gap, and the LFSR/prev_phase are unchanged by idle cycle 1.
- Reset assertion between two valid inputs: no sample_valid for either; outputs read 0 immediately on reset assert.

Source files
------------

// File: rtl/phase_to_amplitude.sv
// Phase-to-amplitude converter: turns an accumulator phase word into a signed
// pulse/saw/triangle/noise sample through a two-register, valid-qualified pipeline.
module phase_to_amplitude #(
  parameter int PHASE_WIDTH  = 32,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_active_high,
  input  logic [PHASE_WIDTH-1:0]         phase_in,
  input  logic                           phase_valid,
  input  logic [2:0]                     wave_select,
  input  logic [7:0]                     pulse_width,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_valid,
  output logic                           wrap_pulse
);

  localparam int P = PHASE_WIDTH;
  localparam int S = SAMPLE_WIDTH;

  typedef enum logic [2:0] {
    WAVE_PULSE    = 3'd0,
    WAVE_SAW      = 3'd1,
    WAVE_TRIANGLE = 3'd2,
    WAVE_NOISE    = 3'd3
  } wave_t;

  logic [P-1:0]  r_prevPhase;
  logic [22:0]   r_lfsr;
  logic          r_s1Valid;
  logic [P-1:0]  r_s1Phase;
  logic [2:0]    r_s1Wave;
  logic [7:0]    r_s1PulseWidth;
  logic          r_s1Wrap;
  logic [S-1:0]  r_s1Noise;

  logic          w_doStep;
  logic [22:0]   w_lfsrNext;
  logic [S-1:0]  w_triFold;
  logic [S-1:0]  w_wave;

  // The LFSR advances only when the coarse phase (top nibble) moves on a valid input.
  assign w_doStep   = phase_valid && (phase_in[P-1 -: 4] != r_prevPhase[P-1 -: 4]);
  assign w_lfsrNext = w_doStep ? {r_lfsr[21:0], r_lfsr[22] ^ r_lfsr[17]} : r_lfsr;

  // Noise bits are captured alongside the phase so a later step cannot leak into this sample.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      r_prevPhase    <= '0;
      r_lfsr         <= 23'h7FFFFF;
      r_s1Valid      <= 1'b0;
      r_s1Phase      <= '0;
      r_s1Wave       <= '0;
      r_s1PulseWidth <= '0;
      r_s1Wrap       <= 1'b0;
      r_s1Noise      <= '0;
    end else if (phase_valid) begin
      r_prevPhase    <= phase_in;
      r_lfsr         <= w_lfsrNext;
      r_s1Valid      <= 1'b1;
      r_s1Phase      <= phase_in;
      r_s1Wave       <= wave_select;
      r_s1PulseWidth <= pulse_width;
      r_s1Wrap       <= (phase_in < r_prevPhase);
      r_s1Noise      <= w_lfsrNext[S-1:0];
    end else begin
      r_s1Valid      <= 1'b0;
      r_s1Wrap       <= 1'b0;
    end
  end

  always_comb begin
    w_triFold = r_s1Phase[P-2 -: S];
    if (r_s1Phase[P-1]) begin
      w_triFold = ~r_s1Phase[P-2 -: S];
    end
    w_wave = '0;
    case (r_s1Wave)
      WAVE_PULSE:    w_wave = (r_s1Phase[P-1 -: 8] < r_s1PulseWidth) ?
                              {1'b0, {(S-1){1'b1}}} : {1'b1, {(S-1){1'b0}}};
      WAVE_SAW:      w_wave = {~r_s1Phase[P-1], r_s1Phase[P-2 -: S-1]};
      WAVE_TRIANGLE: w_wave = {~w_triFold[S-1], w_triFold[S-2:0]};
      WAVE_NOISE:    w_wave = r_s1Noise;
      default:       w_wave = '0;
    endcase
  end

  // Bubbles leave the last sample on the bus and suppress both strobes.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      wrap_pulse   <= 1'b0;
    end else if (r_s1Valid) begin
      sample_out   <= w_wave;
      sample_valid <= 1'b1;
      wrap_pulse   <= r_s1Wrap;
    end else begin
      sample_valid <= 1'b0;
      wrap_pulse   <= 1'b0;
    end
  end

endmodule
